// File: rtl/gerenciador_rolhas.sv
// Cork supply stage: warehouse stock and dispenser count, batch refills on request,
// per-cork consumption from sealing, and low-cork / busy / error indications.
module gerenciador_rolhas #(
    parameter logic [7:0] ESTOQUE_INICIAL = 8'd20,
    parameter logic [7:0] ESTOQUE_MAX     = 8'd99,
    parameter logic [7:0] DISP_MAX        = 8'd15,
    parameter logic [7:0] LOTE            = 8'd5,
    parameter logic [7:0] LIMIAR          = 8'd5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       add_rolha,
    input  logic       consome,
    input  logic       switch_add_estoque,
    output logic [7:0] estoque,
    output logic [7:0] rolha_disponivel,
    output logic       tem_5,
    output logic       tem_rolha,
    output logic       estoque_vazio,
    output logic       ocupado,
    output logic       transf_done,
    output logic       erro
);

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        TRANSFERE = 2'd1,
        FIM       = 2'd2
    } state_t;

    state_t     state_r, state_next_s;
    logic [7:0] est_r, disp_r, batch_r;
    logic [7:0] est_dec_s, est_next_s, disp_inc_s, disp_next_s, batch_next_s;
    logic       add_r, con_r, sw_r, arm_r, erro_r;
    logic       add_ev_s, con_ev_s, sw_ev_s, move_s, con_err_s, fsm_err_s;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] lim);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, lim}) begin
            return lim;
        end else begin
            return sum[7:0];
        end
    endfunction

    // Events are gated by arm_r so a level already high when reset releases is not an edge.
    assign add_ev_s = arm_r & add_rolha & ~add_r;
    assign con_ev_s = arm_r & consome & ~con_r;
    assign sw_ev_s  = arm_r & switch_add_estoque & ~sw_r;
    assign move_s   = (state_r == TRANSFERE) && (est_r != 8'd0) && (disp_r < DISP_MAX);

    // Next counter values: transfer move, consumption and stock addition combined.
    always_comb begin
        est_dec_s   = est_r;
        est_next_s  = est_r;
        disp_inc_s  = disp_r;
        disp_next_s = disp_r;
        con_err_s   = 1'b0;
        if (move_s) begin
            est_dec_s  = est_r - 8'd1;
            disp_inc_s = disp_r + 8'd1;
        end else begin
            est_dec_s  = est_r;
            disp_inc_s = disp_r;
        end
        if (sw_ev_s) begin
            est_next_s = sat_add(est_dec_s, LOTE, ESTOQUE_MAX);
        end else begin
            est_next_s = est_dec_s;
        end
        if (con_ev_s) begin
            if (disp_inc_s == 8'd0) begin
                con_err_s   = 1'b1;
                disp_next_s = 8'd0;
            end else begin
                disp_next_s = disp_inc_s - 8'd1;
            end
        end else begin
            disp_next_s = disp_inc_s;
        end
    end

    // Transfer FSM next state, batch counter and error conditions.
    always_comb begin
        state_next_s = state_r;
        batch_next_s = batch_r;
        fsm_err_s    = 1'b0;
        case (state_r)
            OCIOSO: begin
                if (add_ev_s) begin
                    if (est_r == 8'd0) begin
                        fsm_err_s = 1'b1;
                    end else if (disp_r < DISP_MAX) begin
                        batch_next_s = 8'd0;
                        state_next_s = TRANSFERE;
                    end else begin
                        state_next_s = OCIOSO;
                    end
                end else begin
                    state_next_s = OCIOSO;
                end
            end
            TRANSFERE: begin
                if (move_s) begin
                    batch_next_s = batch_r + 8'd1;
                    if ((batch_next_s == LOTE) || (est_next_s == 8'd0) ||
                        (disp_next_s >= DISP_MAX)) begin
                        state_next_s = FIM;
                    end else begin
                        state_next_s = TRANSFERE;
                    end
                    // Only a stock shortfall makes a short batch an error.
                    fsm_err_s = (est_next_s == 8'd0) && (batch_next_s < LOTE);
                end else begin
                    state_next_s = FIM;
                end
            end
            FIM: begin
                state_next_s = OCIOSO;
            end
            default: begin
                state_next_s = OCIOSO;
            end
        endcase
    end

    // State, counters, edge detectors and error pulse register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= OCIOSO;
            est_r   <= ESTOQUE_INICIAL;
            disp_r  <= 8'd0;
            batch_r <= 8'd0;
            add_r   <= 1'b0;
            con_r   <= 1'b0;
            sw_r    <= 1'b0;
            arm_r   <= 1'b0;
            erro_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            est_r   <= est_next_s;
            disp_r  <= disp_next_s;
            batch_r <= batch_next_s;
            add_r   <= add_rolha;
            con_r   <= consome;
            sw_r    <= switch_add_estoque;
            arm_r   <= 1'b1;
            erro_r  <= con_err_s | fsm_err_s;
        end
    end

    assign estoque          = est_r;
    assign rolha_disponivel = disp_r;
    assign tem_5            = (disp_r == LIMIAR);
    assign tem_rolha        = (disp_r != 8'd0);
    assign estoque_vazio    = (est_r == 8'd0);
    assign ocupado          = (state_r == TRANSFERE);
    assign transf_done      = (state_r == FIM);
    assign erro             = erro_r;

endmodule
